// File: rtl/sdram_to_usb.sv
// Return-path bridge: reads a block of 32-bit words over wishbone and writes them
// to the FX2 IN endpoint FIFO as low/high 16-bit halves, closing short packets.
//
// state   | meaning
// IDLE    | waiting for start
// RD_REQ  | wishbone strobe out, held while stalled
// RD_WAIT | request accepted, waiting for ack
// WR_LO   | low half on FDATA, write when FIFO has room
// WR_HI   | high half on FDATA, then next word or finish
// PKT_END | commit a short final packet
// DONE    | one-cycle completion pulse
module sdram_to_usb #(
    parameter int         LEN_W     = 16,
    parameter int         PKT_WORDS = 256,
    parameter logic [1:0] FIFO_ADDR = 2'b10
) (
    input  logic             CLKOUT,
    input  logic             rst_n,
    input  logic             start,
    input  logic [31:0]      base_addr,
    input  logic [LEN_W-1:0] word_count,
    output logic             busy,
    output logic             done,
    output logic [2:0]       cstate,
    output logic [3:0]       LED,
    input  logic             FLAGB,
    output logic             SLWR,
    output logic             SLRD,
    output logic             SLOE,
    output logic             PKTEND,
    output logic             IFCLK,
    output logic [1:0]       FIFOADR,
    inout  wire  [15:0]      FDATA,
    output logic             cyc_i,
    output logic             stb_i,
    output logic             we_i,
    output logic [3:0]       sel_i,
    output logic [31:0]      addr_i,
    output logic [31:0]      data_i,
    input  logic [31:0]      data_o,
    input  logic             stall_o,
    input  logic             sdram_ack
);
    localparam int PKT_W = $clog2(PKT_WORDS);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_RD_REQ  = 3'd1,
        S_RD_WAIT = 3'd2,
        S_WR_LO   = 3'd3,
        S_WR_HI   = 3'd4,
        S_PKT_END = 3'd5,
        S_DONE    = 3'd6
    } state_t;

    state_t             state_q, state_d;
    logic [31:0]        addr_q, addr_d;
    logic [LEN_W-1:0]   rem_q, rem_d;
    logic [31:0]        hold_q, hold_d;
    logic [PKT_W-1:0]   pkt_q, pkt_d, pkt_inc;
    logic               cyc_q, cyc_d;
    logic               stb_q, stb_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic               wr_st;

    assign pkt_inc = (pkt_q == PKT_W'(PKT_WORDS - 1)) ? '0 : pkt_q + PKT_W'(1);

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        rem_d   = rem_q;
        hold_d  = hold_q;
        pkt_d   = pkt_q;
        cyc_d   = cyc_q;
        stb_d   = stb_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    addr_d = base_addr;
                    rem_d  = word_count;
                    pkt_d  = '0;
                    busy_d = 1'b1;
                    if (word_count == '0) begin
                        state_d = S_DONE;
                        done_d  = 1'b1;
                    end else begin
                        state_d = S_RD_REQ;
                        cyc_d   = 1'b1;
                        stb_d   = 1'b1;
                    end
                end
            end
            S_RD_REQ: begin
                if (!stall_o) begin
                    stb_d   = 1'b0;
                    state_d = S_RD_WAIT;
                end
            end
            S_RD_WAIT: begin
                if (sdram_ack) begin
                    hold_d  = data_o;
                    cyc_d   = 1'b0;
                    state_d = S_WR_LO;
                end
            end
            S_WR_LO: begin
                if (FLAGB) begin
                    pkt_d   = pkt_inc;
                    state_d = S_WR_HI;
                end
            end
            S_WR_HI: begin
                if (FLAGB) begin
                    pkt_d  = pkt_inc;
                    addr_d = addr_q + 32'd1;
                    rem_d  = rem_q - LEN_W'(1);
                    if (rem_q == LEN_W'(1)) begin
                        state_d = S_PKT_END;
                    end else begin
                        state_d = S_RD_REQ;
                        cyc_d   = 1'b1;
                        stb_d   = 1'b1;
                    end
                end
            end
            S_PKT_END: begin
                state_d = S_DONE;
                done_d  = 1'b1;
            end
            S_DONE: begin
                busy_d  = 1'b0;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge CLKOUT or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            addr_q  <= '0;
            rem_q   <= '0;
            hold_q  <= '0;
            pkt_q   <= '0;
            cyc_q   <= 1'b0;
            stb_q   <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            rem_q   <= rem_d;
            hold_q  <= hold_d;
            pkt_q   <= pkt_d;
            cyc_q   <= cyc_d;
            stb_q   <= stb_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    // SLWR follows FLAGB in the same cycle: the FX2 samples on the falling CLKOUT edge.
    assign wr_st   = (state_q == S_WR_LO) || (state_q == S_WR_HI);
    assign SLWR    = ~(wr_st && FLAGB);
    assign PKTEND  = ~((state_q == S_PKT_END) && (pkt_q != '0));
    assign FDATA   = (state_q == S_WR_LO) ? hold_q[15:0]  :
                     (state_q == S_WR_HI) ? hold_q[31:16] : 16'hzzzz;
    assign SLRD    = 1'b1;
    assign SLOE    = 1'b1;
    assign IFCLK   = ~CLKOUT;
    assign FIFOADR = FIFO_ADDR;
    assign cstate  = state_q;
    assign LED     = {2'b00, wr_st && !FLAGB, busy_q};
    assign busy    = busy_q;
    assign done    = done_q;
    assign cyc_i   = cyc_q;
    assign stb_i   = stb_q;
    assign we_i    = 1'b0;
    assign sel_i   = 4'hF;
    assign addr_i  = addr_q;
    assign data_i  = 32'd0;
endmodule

// File: tb/tb_sdram_to_usb.sv
// Bench for sdram_to_usb: SDRAM and FX2 behaviour models with a block-level
// expectation of the read addresses, 16-bit write stream, PKTEND and done.
module tb_sdram_to_usb;
    logic        CLKOUT = 1'b0;
    logic        rst_n, start, FLAGB, stall_o, sdram_ack;
    logic [31:0] base_addr, data_o;
    logic [15:0] word_count;
    logic        busy, done, SLWR, SLRD, SLOE, PKTEND, IFCLK, cyc_i, stb_i, we_i;
    logic [2:0]  cstate;
    logic [3:0]  LED, sel_i;
    logic [1:0]  FIFOADR;
    logic [31:0] addr_i, data_i;
    wire  [15:0] fdata;

    sdram_to_usb dut (
        .CLKOUT(CLKOUT), .rst_n(rst_n), .start(start), .base_addr(base_addr),
        .word_count(word_count), .busy(busy), .done(done), .cstate(cstate), .LED(LED),
        .FLAGB(FLAGB), .SLWR(SLWR), .SLRD(SLRD), .SLOE(SLOE), .PKTEND(PKTEND),
        .IFCLK(IFCLK), .FIFOADR(FIFOADR), .FDATA(fdata), .cyc_i(cyc_i), .stb_i(stb_i),
        .we_i(we_i), .sel_i(sel_i), .addr_i(addr_i), .data_i(data_i), .data_o(data_o),
        .stall_o(stall_o), .sdram_ack(sdram_ack)
    );

    always #5 CLKOUT = ~CLKOUT;

    int n_vec = 0;
    int n_err = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
        end
    endtask

    logic [31:0] mem [logic [31:0]];

    function automatic logic [31:0] mem_rd(input logic [31:0] a);
        if (mem.exists(a)) return mem[a];
        return (a * 32'h9E3779B1) ^ 32'hC3A50F1E;
    endfunction

    logic [15:0] got_wr[$];
    logic [31:0] got_addr[$];
    int  pktend_cnt, stb_cycles, cyc_cycles, done_cnt, led_cnt;
    int  cyc_no = 0, done_cyc = 0, start_cyc = 0;
    bit  accept_seen = 0;
    logic [31:0] acc_addr = '0;

    int  ack_delay = 0, stall_budget = 0, hold_cnt = 0;
    bit  hold_arm = 0, flag_rand = 0, stall_rand = 0;

    // FX2 FIFO observer and wishbone request monitor
    initial begin
        forever begin
            @(negedge CLKOUT);
            cyc_no++;
            if (!SLWR) got_wr.push_back(fdata);
            if (!PKTEND) pktend_cnt++;
            if (stb_i) stb_cycles++;
            if (cyc_i) cyc_cycles++;
            if (LED[1]) led_cnt++;
            if (done) begin
                done_cnt++;
                done_cyc = cyc_no;
            end
            if (stb_i && !stall_o) begin
                got_addr.push_back(addr_i);
                acc_addr    = addr_i;
                accept_seen = 1;
            end
            if ((cstate == 3'd3 || cstate == 3'd4) && !FLAGB) begin
                check("slwr_while_full", {31'd0, SLWR}, 32'd1);
                check("led_full", {31'd0, LED[1]}, 32'd1);
            end
        end
    end

    // SDRAM responder plus FLAGB / stall stimulus
    initial begin
        int rd_cnt;
        bit rd_active;
        logic [31:0] rd_addr;
        rd_cnt = 0; rd_active = 0; rd_addr = '0;
        FLAGB = 1'b1; stall_o = 1'b0; sdram_ack = 1'b0; data_o = '0;
        forever begin
            @(posedge CLKOUT); #1;
            sdram_ack = 1'b0;
            if (accept_seen) begin
                rd_cnt      = ack_delay;
                rd_addr     = acc_addr;
                rd_active   = 1;
                accept_seen = 0;
            end
            if (rd_active) begin
                if (rd_cnt == 0) begin
                    sdram_ack = 1'b1;
                    data_o    = mem_rd(rd_addr);
                    rd_active = 0;
                end else rd_cnt--;
            end
            if (hold_arm && cstate == 3'd4) begin
                hold_cnt = 10;
                hold_arm = 0;
            end
            if (hold_cnt > 0) begin
                FLAGB = 1'b0;
                hold_cnt--;
            end else FLAGB = flag_rand ? ($urandom_range(0, 3) != 0) : 1'b1;
            if (stb_i && stall_budget > 0) begin
                stall_o = 1'b1;
                stall_budget--;
            end else stall_o = (stall_rand && stb_i) ? ($urandom_range(0, 2) == 0) : 1'b0;
        end
    end

    task automatic clear_obs();
        got_wr.delete();
        got_addr.delete();
        pktend_cnt = 0; stb_cycles = 0; cyc_cycles = 0; done_cnt = 0; led_cnt = 0;
    endtask

    task automatic pulse_start(input logic [31:0] base, input int cnt);
        @(posedge CLKOUT); #1;
        base_addr  = base;
        word_count = 16'(cnt);
        start      = 1'b1;
        start_cyc  = cyc_no;
        @(posedge CLKOUT); #1;
        start      = 1'b0;
        base_addr  = $urandom;
        word_count = 16'($urandom);
    endtask

    task automatic run(input logic [31:0] base, input int cnt, input int dly, input bit chk_lat);
        logic [31:0] w, a;
        logic [15:0] e;
        int n;
        clear_obs();
        ack_delay = dly;
        pulse_start(base, cnt);
        check("busy_run", {31'd0, busy}, 32'd1);
        for (int i = 0; i < cnt * 80 + 50 && done_cnt == 0; i++) @(posedge CLKOUT);
        check("done_seen", {31'd0, done_cnt != 0}, 32'd1);
        repeat (3) @(posedge CLKOUT);
        #1;
        check("done_once", done_cnt, 32'd1);
        check("busy_end", {31'd0, busy}, 32'd0);
        if (chk_lat) check("done_lat", done_cyc - start_cyc, (cnt == 0) ? 2 : cnt * (dly + 4) + 3);
        check("n_reads", got_addr.size(), cnt);
        n = (got_addr.size() < cnt) ? got_addr.size() : cnt;
        for (int i = 0; i < n; i++) check("rd_addr", got_addr[i], base + 32'(i));
        check("n_writes", got_wr.size(), 2 * cnt);
        n = (got_wr.size() < 2 * cnt) ? got_wr.size() : 2 * cnt;
        for (int i = 0; i < n; i++) begin
            a = base + 32'(i / 2);
            w = mem_rd(a);
            e = (i % 2) ? w[31:16] : w[15:0];
            check("fdata", {16'd0, got_wr[i]}, {16'd0, e});
        end
        check("pktend", pktend_cnt, ((2 * cnt) % 256 != 0) ? 1 : 0);
    endtask

    initial begin
        rst_n = 1'b0; start = 1'b0; base_addr = '0; word_count = '0;
        #2;
        check("rst_cyc", {31'd0, cyc_i}, 0);
        check("rst_stb", {31'd0, stb_i}, 0);
        check("rst_addr", addr_i, 0);
        check("rst_strobes", {28'd0, SLWR, SLRD, SLOE, PKTEND}, 32'hF);
        check("rst_busy_done", {30'd0, busy, done}, 0);
        check("rst_led", {28'd0, LED}, 0);
        check("rst_state", {29'd0, cstate}, 0);
        check("ifclk", {31'd0, IFCLK}, {31'd0, ~CLKOUT});
        check("fifoadr", {30'd0, FIFOADR}, 32'd2);
        check("wb_const", {we_i, sel_i, 27'd0}, {1'b0, 4'hF, 27'd0});
        check("data_i", data_i, 0);
        repeat (2) @(posedge CLKOUT);
        #1 rst_n = 1'b1;

        run(32'h0, 0, 0, 1);
        check("zero_no_cyc", cyc_cycles, 0);

        mem[32'h10] = 32'hAAAA5555;
        mem[32'h11] = 32'h12345678;
        mem[32'h12] = 32'hDEADBEEF;
        run(32'h10, 3, 3, 1);

        run(32'h200, 128, 0, 1);

        stall_budget = 5;
        run(32'h300, 1, 0, 0);
        check("stall_stb_cycles", stb_cycles, 6);

        hold_arm = 1;
        run(32'h400, 1, 1, 0);
        check("flagb_wait_cycles", led_cnt, 10);

        // abort a transfer while it waits on the SDRAM
        clear_obs();
        ack_delay = 6;
        pulse_start(32'h100, 5);
        for (int i = 0; i < 40 && cstate != 3'd2; i++) begin
            @(posedge CLKOUT); #1;
        end
        check("reach_rd_wait", {29'd0, cstate}, 2);
        rst_n = 1'b0;
        #1;
        check("abort_cyc", {31'd0, cyc_i}, 0);
        check("abort_busy", {31'd0, busy}, 0);
        check("abort_state", {29'd0, cstate}, 0);
        check("abort_strobes", {30'd0, SLWR, PKTEND}, 32'd3);
        check("abort_addr", addr_i, 0);
        repeat (10) @(posedge CLKOUT);
        #1 rst_n = 1'b1;
        check("abort_no_pktend", pktend_cnt, 0);
        run(32'h40, 2, 2, 1);

        flag_rand = 1;
        stall_rand = 1;
        for (int k = 0; k < 10; k++) begin
            logic [31:0] b;
            b = (k % 3 == 0) ? (32'hFFFFFFFF - 32'($urandom_range(0, 5))) : $urandom;
            run(b, $urandom_range(0, 40), $urandom_range(0, 4), 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
